// File: rtl/mem_requester.sv
// Instruction fetch unit with a 2-entry prefetch FIFO, plus an independent
// single-outstanding load/store sequencer with alignment and range checks.
module mem_requester #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 65536
) (
  input  logic        mem_Clk,
  input  logic        mem_Rst_n,
  // fetch, core side
  input  logic        fetch_go,
  input  logic        fetch_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  // fetch, memory side
  output logic        instruction_memory_en,
  output logic [31:0] instruction_memory_a,
  input  logic [31:0] instruction_memory_v,
  // load/store, core side
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_busy,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_fault,
  // load/store, memory side
  output logic [31:0] data_memory_a,
  output logic        data_memory_read,
  output logic        data_memory_write,
  output logic [31:0] data_memory_out_v,
  input  logic [31:0] data_memory_in_v
);

  localparam logic [31:0] LP_LAST = 32'(MEM_BYTES - 4);

  // ---------------- fetch ----------------
  logic [31:0]       r_pc, r_pend_pc;
  logic              r_pend;
  logic [1:0]        r_cnt;
  logic              r_head;
  logic [1:0][31:0]  r_q_inst, r_q_pc;

  logic w_issue, w_push, w_pop, w_wr_idx;

  // r_pend marks the fetch issued last cycle; its data lands at this cycle end.
  assign w_issue  = fetch_go & ~redirect & mem_Rst_n & ((r_cnt + {1'b0, r_pend}) < 2'd2);
  assign w_push   = r_pend & ~redirect;
  assign w_pop    = (r_cnt != 2'd0) & fetch_ready & ~redirect;
  assign w_wr_idx = r_head ^ r_cnt[0];

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) begin
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_cnt     <= '0;
      r_head    <= 1'b0;
      r_q_inst  <= '0;
      r_q_pc    <= '0;
    end else begin
      r_pend    <= w_issue;
      r_pend_pc <= r_pc;
      if (redirect)     r_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_issue) r_pc <= r_pc + 32'd4;
      if (redirect) begin
        r_cnt  <= '0;
        r_head <= 1'b0;
      end else begin
        if (w_push) begin
          r_q_inst[w_wr_idx] <= instruction_memory_v;
          r_q_pc[w_wr_idx]   <= r_pend_pc;
        end
        if (w_pop) r_head <= ~r_head;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign inst_valid            = (r_cnt != 2'd0);
  assign inst                  = inst_valid ? r_q_inst[r_head] : '0;
  assign inst_pc               = inst_valid ? r_q_pc[r_head]   : '0;
  assign instruction_memory_en = w_issue;
  assign instruction_memory_a  = w_issue ? r_pc : '0;

  // ---------------- load/store ----------------
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} ls_state_t;

  ls_state_t   r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_we, r_fault;
  logic        w_bad;

  assign w_bad = (ls_addr[1:0] != 2'b00) | (ls_addr > LP_LAST);

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    ls_busy           = 1'b1;
    ls_done           = 1'b0;
    data_memory_read  = 1'b0;
    data_memory_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        ls_busy = 1'b0;
        if (ls_req) w_next = w_bad ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        data_memory_read  = ~r_we;
        data_memory_write = r_we;
        w_next            = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT:  w_next = S_DONE;
      S_DONE: begin
        ls_done = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && ls_req) begin
        r_addr  <= ls_addr;
        r_wdata <= ls_wdata;
        r_we    <= ls_we;
        r_fault <= w_bad;
      end
      // faulted loads never reach WAIT, so ls_rdata survives them
      if (r_state == S_WAIT) r_rdata <= data_memory_in_v;
    end
  end

  assign ls_rdata          = r_rdata;
  assign ls_fault          = ls_done & r_fault;
  assign data_memory_a     = (r_state == S_ISSUE) ? r_addr : '0;
  assign data_memory_out_v = data_memory_write ? r_wdata : '0;

endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester: fetch stream and load/store completions
// are compared against queued expectations with simple memory models.
module tb_mem_requester;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        mem_Rst_n, fetch_go, fetch_ready, redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        imem_en;
  logic [31:0] imem_a, imem_v;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_busy, ls_done, ls_fault;
  logic [31:0] ls_rdata;
  logic [31:0] da, dout, din;
  logic        drd, dwr;

  mem_requester #(.RESET_PC(32'h0), .MEM_BYTES(65536)) dut (
    .mem_Clk(clk), .mem_Rst_n(mem_Rst_n),
    .fetch_go(fetch_go), .fetch_ready(fetch_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .instruction_memory_en(imem_en), .instruction_memory_a(imem_a), .instruction_memory_v(imem_v),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_busy(ls_busy), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .data_memory_a(da), .data_memory_read(drd), .data_memory_write(dwr),
    .data_memory_out_v(dout), .data_memory_in_v(din)
  );

  function automatic logic [31:0] iword(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // memory models: registered read data, all-ones while the strobe is low
  logic [31:0] dmem [0:16383];
  always @(posedge clk) imem_v <= imem_en ? iword(imem_a) : 32'hFFFF_FFFF;
  always @(posedge clk) begin
    if (dwr) dmem[da[15:2]] <= dout;
    din <= drd ? dmem[da[15:2]] : 32'hFFFF_FFFF;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic        fault;
    logic [31:0] rdata;
    int          nrd;
    int          nwr;
  } ls_exp_t;

  logic [31:0] fq[$];
  ls_exp_t     lq[$];
  logic [31:0] exp_fa = 32'h0;
  int n_strobe = 0, n_pop = 0, first_en = -1, first_vld = -1;
  logic [31:0] first_vld_pc = 32'hFFFF_FFFF;
  int n_rd = 0, n_wr = 0, req_cyc = 0, ls_done_cnt = 0;
  logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;

  task automatic refill_fq(input logic [31:0] base);
    fq.delete();
    for (int i = 0; i < 300; i++) fq.push_back(base + 32'(4 * i));
    exp_fa = base;
  endtask

  // monitor
  always @(negedge clk) begin
    ls_exp_t le;
    logic [31:0] e;
    if (mem_Rst_n) begin
      if (imem_en) begin
        chk("fetch_a", imem_a, exp_fa);
        exp_fa = exp_fa + 32'd4;
        n_strobe++;
        if (first_en < 0) first_en = cyc;
      end
      if (inst_valid && first_vld < 0) begin
        first_vld    = cyc;
        first_vld_pc = inst_pc;
      end
      if (inst_valid && fetch_ready && !redirect) begin
        n_pop++;
        if (fq.size() == 0) chk("fq_nonempty", 32'(fq.size()), 32'd1);
        else begin
          e = fq.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst", inst, iword(e));
        end
      end
      if (drd) n_rd++;
      if (dwr) begin
        n_wr++;
        chk("st_addr", da, cur_addr);
        chk("st_data", dout, cur_wdata);
      end
      if (ls_done) begin
        ls_done_cnt++;
        if (lq.size() == 0) chk("lq_nonempty", 32'(lq.size()), 32'd1);
        else begin
          le = lq.pop_front();
          chk("ls_lat", 32'(cyc - req_cyc), 32'(le.lat));
          chk("ls_fault", 32'(ls_fault), 32'(le.fault));
          chk("ls_rdata", ls_rdata, le.rdata);
          chk("ls_nrd", 32'(n_rd), 32'(le.nrd));
          chk("ls_nwr", 32'(n_wr), 32'(le.nwr));
        end
      end
    end
  end

  task automatic ls_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int lat, input logic fault, input logic [31:0] rd,
                       input int nrd, input int nwr);
    ls_exp_t e;
    int start;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
    req_cyc = cyc; n_rd = 0; n_wr = 0; cur_addr = addr; cur_wdata = wd;
    e.lat = lat; e.fault = fault; e.rdata = rd; e.nrd = nrd; e.nwr = nwr;
    lq.push_back(e);
    start = ls_done_cnt;
    @(posedge clk); #1;
    ls_req = 1'b0;
    for (int i = 0; i < 10 && ls_done_cnt == start; i++) @(negedge clk);
    #1;
    chk("ls_done_seen", 32'(ls_done_cnt - start), 32'd1);
  endtask

  initial begin
    int  start;
    bit  found;
    ls_exp_t e;
    mem_Rst_n = 1'b0; fetch_go = 1'b1; fetch_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    refill_fq(32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_ls_busy", 32'(ls_busy), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_dstrobe", {30'd0, drd, dwr}, 32'd0);

    // reset release, free-running fetch
    @(posedge clk); #1;
    mem_Rst_n = 1'b1;
    for (int i = 0; i < 20 && first_vld < 0; i++) @(negedge clk);
    #1;
    chk("first_vld_lat", 32'(first_vld - first_en), 32'd2);
    chk("first_vld_pc", first_vld_pc, 32'h0);
    repeat (10) @(posedge clk);

    // stall: FIFO fills to exactly two entries
    #1 fetch_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("stall_en", 32'(imem_en), 32'd0);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_held", 32'(n_strobe - n_pop), 32'd2);
    @(posedge clk); #1;
    fetch_ready = 1'b1;
    repeat (8) @(posedge clk);

    // redirect while one fetch is outstanding
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_en) found = 1'b1;
    end
    chk("redir_found", 32'(found), 32'd1);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h103;
    @(posedge clk); #1;
    redirect = 1'b0;
    refill_fq(32'h100);
    @(negedge clk); #1;
    chk("redir_flush", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
    chk("redir_pc", inst_pc, 32'h100);

    // load/store, fetch keeps running alongside
    ls_op(1'b1, 32'h200,  32'hDEAD_BEEF, 2, 1'b0, 32'h0,         0, 1);
    ls_op(1'b0, 32'h200,  32'h0,         3, 1'b0, 32'hDEAD_BEEF, 1, 0);
    ls_op(1'b0, 32'h202,  32'h0,         1, 1'b1, 32'hDEAD_BEEF, 0, 0);
    ls_op(1'b0, 32'hFFFD, 32'h0,         1, 1'b1, 32'hDEAD_BEEF, 0, 0);
    ls_op(1'b1, 32'hFFFC, 32'hA5A5_1234, 2, 1'b0, 32'hDEAD_BEEF, 0, 1);
    ls_op(1'b0, 32'hFFFC, 32'h0,         3, 1'b0, 32'hA5A5_1234, 1, 0);
    ls_op(1'b0, 32'h1_0000, 32'h0,       1, 1'b1, 32'hA5A5_1234, 0, 0);

    // second request while busy is ignored
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
    req_cyc = cyc; n_rd = 0; n_wr = 0; cur_addr = 32'h200;
    e.lat = 3; e.fault = 1'b0; e.rdata = 32'hDEAD_BEEF; e.nrd = 1; e.nwr = 0;
    lq.push_back(e);
    start = ls_done_cnt;
    @(posedge clk); #1;
    ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    ls_req = 1'b0;
    repeat (6) @(posedge clk);
    chk("busy_ignored", 32'(ls_done_cnt - start), 32'd1);

    // reset while the load sits in WAIT
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
    start = ls_done_cnt;
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(posedge clk); #1;
    mem_Rst_n = 1'b0;
    @(posedge clk); #1;
    mem_Rst_n = 1'b1;
    refill_fq(32'h0);
    @(negedge clk); #1;
    chk("wrst_busy", 32'(ls_busy), 32'd0);
    chk("wrst_done", 32'(ls_done), 32'd0);
    chk("wrst_rdata", ls_rdata, 32'd0);
    chk("wrst_valid", 32'(inst_valid), 32'd0);
    repeat (6) @(posedge clk);
    chk("wrst_no_done", 32'(ls_done_cnt - start), 32'd0);

    #1 fetch_go = 1'b0;
    repeat (6) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-002 Parameter MEM_BYTES, default 65536, sets the byte size of the backing memory used for the load/store range check.
REQ-003 mem_Clk  in  1  sets the single clock; all state changes on its rising edge.
REQ-004 mem_Rst_n  in  1  sets a synchronous, active-low reset.
REQ-005 Fetch core-side ports SHALL be:
- fetch_go  in  1  enables fetching.
- fetch_ready  in  1  means the core accepts inst this cycle.
- redirect  in  1  requests a PC change.
- redirect_pc  in  32  is the new PC.
REQ-006 Fetch outputs SHALL be:
- inst_valid  out  1  means inst is valid.
- inst  out  32  is the instruction word.
- inst_pc  out  32  is the address of inst.
REQ-007 Fetch memory-side ports SHALL be:
- instruction_memory_en  out  1  is the fetch strobe.
- instruction_memory_a  out  32  is the fetch byte address.
- instruction_memory_v  in  32  is the registered fetch data, valid the cycle after the strobe.
REQ-008 Load/store core-side inputs SHALL be:
- ls_req  in  1  requests a load or store.
- ls_we  in  1  selects store when 1, load when 0.
- ls_addr  in  32  is the byte address.
- ls_wdata  in  32  is the store data.
REQ-009 Load/store core-side outputs SHALL be:
- ls_busy  out  1  means a request is in progress.
- ls_done  out  1  is a one-cycle completion pulse.
- ls_rdata  out  32  is the load result.
- ls_fault  out  1  flags a rejected request and is valid with ls_done.
REQ-010 Data memory-side ports SHALL be:
- data_memory_a  out  32  is the data byte address.
- data_memory_read  out  1  is the load strobe.
- data_memory_write  out  1  is the store strobe.
- data_memory_out_v  out  32  is the store data, big-endian byte order with [31:24] at address a.
- data_memory_in_v  in  32  is the load data, valid the cycle after the read strobe.

Function
REQ-011 Fetch SHALL keep a PC register and a 2-entry instruction FIFO; inst, inst_pc and inst_valid SHALL come from the FIFO head.
REQ-012 instruction_memory_en SHALL be 1 in a cycle iff all of these hold: fetch_go=1, redirect=0, not in reset, and FIFO occupancy + outstanding requests < 2.
REQ-013 When instruction_memory_en=1, instruction_memory_a SHALL equal PC, and PC SHALL advance by 4 at the cycle end, wrapping modulo 2^32.
REQ-014 A fetch issued in cycle c SHALL have its response sampled from instruction_memory_v at the end of cycle c+1 and pushed with its PC; inst_valid SHALL therefore rise no earlier than cycle c+2.
REQ-015 A FIFO pop SHALL occur when inst_valid=1 and fetch_ready=1; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-016 When the FIFO is full, no fetch SHALL issue; the FIFO SHALL never overflow, and the all-ones value the memory returns while the strobe is low SHALL never be pushed.
REQ-017 On redirect=1:
- The FIFO SHALL be flushed at the cycle end, so inst_valid=0 the next cycle.
- Any response outstanding at that point SHALL be discarded.
- PC SHALL become {redirect_pc[31:2],2'b00}.
- Issue SHALL resume the next cycle.
- redirect SHALL take priority over a simultaneous pop.
REQ-018 The load/store FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; ls_busy SHALL be 1 in every state except IDLE.
REQ-019 In IDLE, an ls_req=1 SHALL be accepted; the address, ls_we and ls_wdata SHALL be latched.
REQ-020 An accepted request SHALL be rejected if ls_addr[1:0]!=0 or ls_addr>MEM_BYTES-4.
- On reject: IDLE->DONE with ls_fault=1, and no memory strobe is issued.
- Otherwise: IDLE->ISSUE.
REQ-021 In ISSUE, data_memory_read (load) or data_memory_write (store) SHALL be 1 for exactly one cycle, together with data_memory_a and data_memory_out_v.
- A load SHALL go ISSUE->WAIT.
- A store SHALL go ISSUE->DONE.
REQ-022 In WAIT, data_memory_in_v SHALL be captured into ls_rdata at the cycle end, then WAIT->DONE.
REQ-023 In DONE, ls_done SHALL be 1 for one cycle, then DONE->IDLE; load latency is req-to-done 3 cycles, store latency is 2 cycles.
REQ-024 data_memory_read and data_memory_write SHALL never be 1 in the same cycle, and both SHALL be 0 in every state except ISSUE.
REQ-025 ls_req SHALL be ignored while ls_busy=1.
REQ-026 ls_rdata SHALL hold its value until the next successful load completes; a faulted load SHALL leave ls_rdata unchanged.
REQ-027 The fetch and load/store paths SHALL operate concurrently and independently.

Reset
REQ-028 While mem_Rst_n=0 at a clock edge, the block SHALL reset to:
- PC=RESET_PC, FIFO empty, outstanding count 0, FSM in IDLE.
- All outputs 0, including ls_rdata, inst and inst_pc.
REQ-029 On reset mid-operation, an outstanding fetch response SHALL be discarded, and a store already strobed SHALL NOT be undone.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset release with fetch_go=1 and fetch_ready=1 -> strobes at a=0,4,8,...; inst_valid first rises 2 cycles after the first strobe, with inst_pc=0.
- fetch_ready=0 for 6 cycles -> exactly 2 entries held, en=0 after the FIFO fills; resumes in order once fetch_ready=1.
- redirect with redirect_pc=32'h103 while 1 fetch is outstanding -> inst_valid=0 next cycle; the next inst_pc is 32'h100; the stale response is never presented.
- Store 32'hDEADBEEF at 32'h200, then load 32'h200 -> one write strobe; ls_done 2 cycles after req; the load returns DEADBEEF 3 cycles after req.
- Load at 32'h202, and load at 32'hFFFD -> each gives ls_done=1 with ls_fault=1 one cycle after req, no strobe, ls_rdata unchanged.
- ls_req pulsed while busy, and a reset in WAIT -> the extra request is ignored; after reset the FSM is IDLE, ls_done=0 and ls_rdata=0.
